demux_1ton_stream: RTL
======================

// Module: demux_1toN_stream
// PURPOSE
//   Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake.
//   Routes packets (beats framed by s_last) from one input stream to one of N output channels.
//   The channel is locked for the whole packet.
//   Successor to the combinational 1-to-4 demux; used in front of per-channel datapaths.
// PARAMETERS
//   WIDTH  8               data width per beat
//   N      4               number of output channels (>=2)
//   SEL_W  $clog2(N)       width of channel select (derived; do not override)
// PORTS
//   clk      in   1          single clock, rising edge
//   rst_n    in   1          asynchronous, active-low reset
//   s_data   in   WIDTH      input beat data
//   s_sel    in   SEL_W      destination channel; sampled on first beat of packet only
//   s_last   in   1          marks final beat of packet
//   s_valid  in   1          input beat valid
//   s_ready  out  1          input beat accepted when s_valid&&s_ready
//   m_data   out  N*WIDTH    channel k = m_data[k*WIDTH +: WIDTH]
//   m_last   out  N          per-channel last flag
//   m_valid  out  N          per-channel valid, at most one bit set (one-hot or zero)
//   m_ready  in   N          per-channel ready
//   drop_cnt out  16         dropped-beat counter (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): m_valid=0, m_last=0, m_data=0, drop_cnt=0, FSM->IDLE, lock cleared.
//   Output stage: one holding register (data, last, dst); latency 1 cycle input->output.
//   Unselected channel slices of m_data and m_last are driven 0, never stale data.
//   FSM IDLE: next accepted beat is a packet head; dst<=s_sel; ->LOCK unless s_last (stay IDLE).
//   FSM LOCK: s_sel ignored; beats go to locked dst; accepted beat with s_last=1 -> IDLE.
//   Accept rule: s_ready = !hold_valid || m_ready[hold_dst]; full throughput, 1 beat/cycle.
//   Beats are never dropped or duplicated for legal dst.
//   Output beat is held stable until m_ready of its channel is high.
//   Simultaneous drain+load: the register is reloaded in the same cycle; no bubble.
//   This also applies when the new packet targets a different channel.
//   Illegal dst (s_sel>=N, only possible when N not a power of 2):
//     s_ready=1, beat is consumed, no m_valid asserted, and the packet lock still follows s_last.
//   Single-beat packet (s_last on head): routed normally, FSM remains IDLE.
//   Reset mid-packet: lock lost, held beat discarded, next accepted beat is a new head.
//   m_ready on a channel with no valid beat is ignored.
// CONFIGURATION
//   Macro DEMUX_STATS_EN:
//     defined: drop_cnt increments by 1 per beat consumed for an illegal dst.
//       The counter saturates at 16'hFFFF and is cleared only by reset.
//     undefined: drop_cnt is tied to 16'h0000 with no counter logic; the port is kept.
//   Routing behaviour is identical either way.
// TESTING
//   1. N=4: 3-beat packet sel=2, data A1,A2,A3, all m_ready=1.
//      -> m_valid=4'b0100 on 3 consecutive cycles, 1 cycle after input; m_last on A3 only.
//   2. Mid-packet s_sel changed 2->0 on beat 2.
//      -> all beats still on ch2; next packet head with sel=0 goes to ch0.
//   3. Backpressure: m_ready[1]=0 for 5 cycles while ch1 beat held.
//      -> s_ready=0, m_data slice 1 stable; release -> beat exits, next beat loads same cycle.
//   4. Back-to-back single-beat packets sel=0,1,2,3 with all ready.
//      -> m_valid 0001,0010,0100,1000 on 4 consecutive cycles; other slices 0.
//   5. N=3 with DEMUX_STATS_EN: 2-beat packet sel=3.
//      -> no m_valid, s_ready=1, drop_cnt=2. Without the macro: drop_cnt=0.
//   6. Assert rst_n=0 async mid-packet with a beat held.
//      -> m_valid=0 immediately; after release, sel=1 head routes to ch1.

Source files
------------

// File: rtl/demux_1ton_stream_if.sv
// Stream bundle for demux_1ton_stream: one input stream (s_*) fanned out to N output channels (m_*).
// The master modport is the upstream/downstream side; the slave modport is the demux itself.
interface demux_1ton_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic [WIDTH-1:0]   s_data;
  logic [SEL_W-1:0]   s_sel;
  logic               s_last;
  logic               s_valid;
  logic               s_ready;
  logic [N*WIDTH-1:0] m_data;
  logic [N-1:0]       m_last;
  logic [N-1:0]       m_valid;
  logic [N-1:0]       m_ready;

  modport master (
    output s_data, s_sel, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid
  );

  modport slave (
    input  s_data, s_sel, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid
  );
endinterface

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N packet demultiplexer; the destination is locked from head beat to s_last.
// Optional macro DEMUX_STATS_EN enables the saturating dropped-beat counter on drop_cnt.
module demux_1ton_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1ton_stream_if.slave bus,
  output logic [15:0]        drop_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] lock_dst;
  logic [SEL_W-1:0] cur_dst;
  logic [SEL_W-1:0] hold_dst;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             hold_last;
  logic             hold_ready;
  logic             dst_legal;
  logic             accept;

  assign cur_dst   = (state == ST_IDLE) ? bus.s_sel : lock_dst;
  assign dst_legal = int'(cur_dst) < N;

  always_comb begin
    hold_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (hold_dst == SEL_W'(k)) hold_ready = bus.m_ready[k];
    end
  end

  // Beats for a nonexistent channel are swallowed even while a legal beat is held.
  assign bus.s_ready = !hold_valid || hold_ready || !dst_legal;
  assign accept      = bus.s_valid && bus.s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lock_dst <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        lock_dst <= bus.s_sel;
        state    <= bus.s_last ? ST_IDLE : ST_LOCK;
      end else if (bus.s_last) begin
        state <= ST_IDLE;
      end
    end
  end

  // A draining beat and a newly accepted beat swap in the same cycle, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
      hold_dst   <= '0;
    end else if (accept && dst_legal) begin
      hold_valid <= 1'b1;
      hold_last  <= bus.s_last;
      hold_data  <= bus.s_data;
      hold_dst   <= cur_dst;
    end else if (hold_valid && hold_ready) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.m_data  = '0;
    bus.m_last  = '0;
    bus.m_valid = '0;
    for (int k = 0; k < N; k++) begin
      if (hold_valid && hold_dst == SEL_W'(k)) begin
        bus.m_data[k*WIDTH +: WIDTH] = hold_data;
        bus.m_last[k]                = hold_last;
        bus.m_valid[k]               = 1'b1;
      end
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 16'h0000;
    end else if (accept && !dst_legal && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule
